hazard_scheduler: RTL and testbench
===================================

// Module: hazard_scheduler
// PURPOSE
//  Stall/bubble controller that sequences the ID_EX pipeline register and the stages upstream of it.
//  Keeps a 3-slot write scoreboard (EX, MEM, WB): 7-bit unified register address (URA) plus a T_new countdown per slot.
//  Also tracks the mult/div busy counter.
//  Each cycle it decides whether the instruction in ID may advance; if not, it holds PC and IF_ID and flushes ID_EX.
// PARAMETERS
//  MULT_CYCLES  5   EX-side busy cycles loaded by a multiply (1..15)
//  DIV_CYCLES   10  EX-side busy cycles loaded by a divide (1..15)
// PORTS
//  clk            in   1  single clock, rising edge
//  reset          in   1  synchronous, active-high; clears scoreboard and busy counter
//  id_rs_URA      in   7  source A URA of ID instruction (0 = none)
//  id_rt_URA      in   7  source B URA of ID instruction (0 = none)
//  id_T_use_rs    in   2  cycles until source A is consumed
//  id_T_use_rt    in   2  cycles until source B is consumed
//  id_rd_URA      in   7  destination URA written by ID instruction (0 = no write)
//  id_T_new       in   2  cycles after entering EX until result is forwardable
//  id_md_start    in   1  ID instruction starts mult/div
//  id_md_is_div   in   1  qualifies id_md_start: 1 = divide, 0 = multiply
//  id_md_use      in   1  ID instruction reads/writes HI/LO or starts mult/div
//  pc_enable      out  1  PC register enable
//  if_id_enable   out  1  IF_ID register enable
//  id_ex_flush    out  1  OR'd into ID_EX reset; inserts a bubble
//  md_busy        out  1  busy counter != 0
// BEHAVIOUR
//  - Decisions are combinational from registered state plus ID inputs; no added latency.
//  - stall = hz_rs | hz_rt | hz_md. Outputs: pc_enable = if_id_enable = ~stall, id_ex_flush = stall.
//  - hz_rs: id_rs_URA != 0 and the youngest slot (EX > MEM > WB) with URA == id_rs_URA has t_new > id_T_use_rs.
//    Older matches are ignored once a younger match exists. hz_rt is defined the same way on rt.
//  - hz_md: id_md_use & (md_cnt != 0).
//  - Scoreboard update per clock edge (reset not asserted):
//    - WB <= {MEM.ura, sat_dec(MEM.t)}
//    - MEM <= {EX.ura, sat_dec(EX.t)}
//    - EX <= stall ? {0, 0} : {id_rd_URA, id_T_new}
//    - sat_dec(0) = 0.
//    - The WB slot retires on the next edge; matches against it use its stored t_new.
//  - Busy counter md_cnt (4 bits):
//    - if ~stall & id_md_start: load (id_md_is_div ? DIV_CYCLES : MULT_CYCLES)
//    - else if md_cnt != 0: decrement; saturates at 0, never wraps
//    - Loading takes priority over decrementing in the same cycle.
//  - A stalled mult/div start does not load the counter. Because id_md_use covers the start itself, a new start waits for 0.
//  - Reset:
//    - In the cycle reset is high, stall is forced 0: pc_enable = if_id_enable = 1, id_ex_flush = 0, md_busy = 0.
//    - After the edge: all slots {0, 0}, md_cnt = 0.
//    - Mid-operation reset discards pending hazards and busy time; no stall is carried across reset.
//  - URA 0 never matches (hardwired zero); id_rd_URA = 0 stores an empty slot.
//  - rs == rt with both hazards counts as one stall; no double counting.
// TESTING
//  1. Reset, then ID rs=5, T_use=0; empty scoreboard -> pc_enable=1, id_ex_flush=0.
//  2. lw-use: cycle0 ID rd=8, T_new=2; cycle1 ID rs=8, T_use=0
//     -> stall in cycles 1-2 (EX t=2, then MEM t=1); advance in cycle 3 (WB t=0); exactly two bubbles.
//  3. Youngest match: EX holds {9, t=0}, MEM holds {9, t=1}; ID rs=9, T_use=0 -> no stall.
//  4. mult, then mfhi next: MULT_CYCLES=5 -> mfhi stalls 5 cycles, md_busy falls, mfhi issues on cycle 6.
//     div then div: the second div waits DIV_CYCLES=10.
//  5. Hazard on rs=0 with rd=0 in EX, T_new=3 -> no stall.
//  6. Assert reset during a div (md_cnt=7) and a pending lw hazard -> next cycle md_busy=0, no stall.

Source files
------------

// File: rtl/hazard_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_scheduler                                              |
// | Purpose  : ID-stage stall/bubble control from a 3-slot write scoreboard  |
// |            (EX/MEM/WB) plus a mult/div busy counter.                     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module hazard_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] id_rs_URA,
  input  logic [6:0] id_rt_URA,
  input  logic [1:0] id_T_use_rs,
  input  logic [1:0] id_T_use_rt,
  input  logic [6:0] id_rd_URA,
  input  logic [1:0] id_T_new,
  input  logic       id_md_start,
  input  logic       id_md_is_div,
  input  logic       id_md_use,
  output logic       pc_enable,
  output logic       if_id_enable,
  output logic       id_ex_flush,
  output logic       md_busy
);

  localparam logic [3:0] c_mult_load = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_load  = 4'(DIV_CYCLES);

  logic [6:0] r_ex_ura, r_mem_ura, r_wb_ura;
  logic [1:0] r_ex_t,   r_mem_t,   r_wb_t;
  logic [3:0] r_md_cnt;

  logic w_hz_rs, w_hz_rt, w_hz_md, w_stall;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Only the youngest matching slot decides; older writers are shadowed.
  function automatic logic src_hazard(
    input logic [6:0] src,   input logic [1:0] t_use,
    input logic [6:0] ex_u,  input logic [1:0] ex_t,
    input logic [6:0] mem_u, input logic [1:0] mem_t,
    input logic [6:0] wb_u,  input logic [1:0] wb_t
  );
    logic hz;
    hz = 1'b0;
    if (src != 7'd0) begin
      if (ex_u == src)       hz = (ex_t  > t_use);
      else if (mem_u == src) hz = (mem_t > t_use);
      else if (wb_u == src)  hz = (wb_t  > t_use);
    end
    return hz;
  endfunction

  always_comb begin
    w_hz_rs = src_hazard(id_rs_URA, id_T_use_rs, r_ex_ura, r_ex_t,
                         r_mem_ura, r_mem_t, r_wb_ura, r_wb_t);
    w_hz_rt = src_hazard(id_rt_URA, id_T_use_rt, r_ex_ura, r_ex_t,
                         r_mem_ura, r_mem_t, r_wb_ura, r_wb_t);
    w_hz_md = id_md_use & (r_md_cnt != 4'd0);
    w_stall = ~reset & (w_hz_rs | w_hz_rt | w_hz_md);
  end

  assign pc_enable    = ~w_stall;
  assign if_id_enable = ~w_stall;
  assign id_ex_flush  = w_stall;
  assign md_busy      = ~reset & (r_md_cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_ura  <= 7'd0;
      r_ex_t    <= 2'd0;
      r_mem_ura <= 7'd0;
      r_mem_t   <= 2'd0;
      r_wb_ura  <= 7'd0;
      r_wb_t    <= 2'd0;
      r_md_cnt  <= 4'd0;
    end else begin
      r_wb_ura  <= r_mem_ura;
      r_wb_t    <= sat_dec(r_mem_t);
      r_mem_ura <= r_ex_ura;
      r_mem_t   <= sat_dec(r_ex_t);
      if (w_stall) begin
        r_ex_ura <= 7'd0;
        r_ex_t   <= 2'd0;
      end else begin
        r_ex_ura <= id_rd_URA;
        r_ex_t   <= id_T_new;
      end
      // A stalled start must not load, so load is gated on ~stall.
      if (~w_stall & id_md_start)
        r_md_cnt <= id_md_is_div ? c_div_load : c_mult_load;
      else if (r_md_cnt != 4'd0)
        r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hazard_scheduler                                           |
// | Purpose  : Directed self-checking bench for hazard_scheduler.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_hazard_scheduler;

  logic       clk;
  logic       reset;
  logic [6:0] id_rs_URA, id_rt_URA, id_rd_URA;
  logic [1:0] id_T_use_rs, id_T_use_rt, id_T_new;
  logic       id_md_start, id_md_is_div, id_md_use;
  logic       pc_enable, if_id_enable, id_ex_flush, md_busy;

  int n_tests;
  int n_fail;

  hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs_URA    (id_rs_URA),
    .id_rt_URA    (id_rt_URA),
    .id_T_use_rs  (id_T_use_rs),
    .id_T_use_rt  (id_T_use_rt),
    .id_rd_URA    (id_rd_URA),
    .id_T_new     (id_T_new),
    .id_md_start  (id_md_start),
    .id_md_is_div (id_md_is_div),
    .id_md_use    (id_md_use),
    .pc_enable    (pc_enable),
    .if_id_enable (if_id_enable),
    .id_ex_flush  (id_ex_flush),
    .md_busy      (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and checked mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_nop();
    id_rs_URA = 7'd0; id_rt_URA = 7'd0; id_rd_URA = 7'd0;
    id_T_use_rs = 2'd0; id_T_use_rt = 2'd0; id_T_new = 2'd0;
    id_md_start = 1'b0; id_md_is_div = 1'b0; id_md_use = 1'b0;
  endtask

  task automatic do_reset();
    id_nop();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    id_nop();
    id_rs_URA = 7'd5;
    id_md_use = 1'b1;
    #1;
    n_tests++;
    if ({pc_enable, if_id_enable, id_ex_flush, md_busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_outputs: got pc=%b ifid=%b flush=%b busy=%b, want 1 1 0 0",
               pc_enable, if_id_enable, id_ex_flush, md_busy);
    end
    step();
    reset = 1'b0;
    id_nop();
    id_rs_URA = 7'd5;
    #1;
    n_tests++;
    if (pc_enable !== 1'b1 || id_ex_flush !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_sb: got pc=%b flush=%b busy=%b, want 1 0 0",
               pc_enable, id_ex_flush, md_busy);
    end
    step();
  endtask

  task automatic test_lw_use();
    do_reset();
    id_nop(); id_rd_URA = 7'd8; id_T_new = 2'd2;
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b0) begin
      n_fail++; $display("FAIL lw_issue: flush=%b, want 0", id_ex_flush);
    end
    step();
    id_nop(); id_rs_URA = 7'd8;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_tests++;
      if (id_ex_flush !== (c < 3) || pc_enable !== (c >= 3) || if_id_enable !== (c >= 3)) begin
        n_fail++;
        $display("FAIL lw_use_c%0d: got flush=%b pc=%b ifid=%b, want flush=%b",
                 c, id_ex_flush, pc_enable, if_id_enable, (c < 3));
      end
      step();
    end
  endtask

  task automatic test_rt_and_tuse();
    // rt hazard with T_new=1: exactly one bubble
    do_reset();
    id_nop(); id_rd_URA = 7'd12; id_T_new = 2'd1;
    step();
    id_nop(); id_rt_URA = 7'd12;
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b1) begin
      n_fail++; $display("FAIL rt_stall: flush=%b, want 1", id_ex_flush);
    end
    step();
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b0) begin
      n_fail++; $display("FAIL rt_release: flush=%b, want 0", id_ex_flush);
    end
    step();
    // t_new equal to T_use does not stall
    id_nop(); id_rd_URA = 7'd20; id_T_new = 2'd2;
    step();
    id_nop(); id_rs_URA = 7'd20; id_T_use_rs = 2'd2;
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b0) begin
      n_fail++; $display("FAIL tuse_equal: flush=%b, want 0", id_ex_flush);
    end
    // rs == rt both hazardous: still exactly two bubbles
    do_reset();
    id_nop(); id_rd_URA = 7'd30; id_T_new = 2'd2;
    step();
    id_nop(); id_rs_URA = 7'd30; id_rt_URA = 7'd30;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_tests++;
      if (id_ex_flush !== (c < 3)) begin
        n_fail++;
        $display("FAIL rs_eq_rt_c%0d: flush=%b, want %b", c, id_ex_flush, (c < 3));
      end
      step();
    end
  endtask

  task automatic test_youngest_match();
    do_reset();
    id_nop(); id_rd_URA = 7'd9; id_T_new = 2'd2;
    step();
    id_nop(); id_rd_URA = 7'd9; id_T_new = 2'd0;
    step();
    id_nop(); id_rs_URA = 7'd9;
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b0 || pc_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL youngest_match: flush=%b pc=%b, want 0 1", id_ex_flush, pc_enable);
    end
    step();
  endtask

  task automatic test_zero_ura();
    do_reset();
    id_nop(); id_rd_URA = 7'd0; id_T_new = 2'd3;
    step();
    id_nop(); id_rs_URA = 7'd0; id_rt_URA = 7'd0;
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b0) begin
      n_fail++; $display("FAIL zero_ura: flush=%b, want 0", id_ex_flush);
    end
    step();
  endtask

  task automatic test_mult_mfhi();
    do_reset();
    id_nop(); id_md_start = 1'b1; id_md_use = 1'b1;
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++; $display("FAIL mult_issue: flush=%b busy=%b, want 0 0", id_ex_flush, md_busy);
    end
    step();
    id_nop(); id_md_use = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      n_tests++;
      if (id_ex_flush !== (c <= 5) || md_busy !== (c <= 5)) begin
        n_fail++;
        $display("FAIL mfhi_c%0d: flush=%b busy=%b, want %b %b",
                 c, id_ex_flush, md_busy, (c <= 5), (c <= 5));
      end
      step();
    end
  endtask

  task automatic test_back_to_back_div();
    do_reset();
    id_nop(); id_md_start = 1'b1; id_md_is_div = 1'b1; id_md_use = 1'b1;
    step();
    for (int c = 1; c <= 11; c++) begin
      #1;
      n_tests++;
      if (id_ex_flush !== (c <= 10)) begin
        n_fail++;
        $display("FAIL div2_c%0d: flush=%b, want %b", c, id_ex_flush, (c <= 10));
      end
      step();
    end
    // second div issued on cycle 11 and has now loaded its own count
    id_nop();
    #1;
    n_tests++;
    if (md_busy !== 1'b1 || id_ex_flush !== 1'b0) begin
      n_fail++; $display("FAIL div2_loaded: busy=%b flush=%b, want 1 0", md_busy, id_ex_flush);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    id_nop(); id_md_start = 1'b1; id_md_is_div = 1'b1; id_md_use = 1'b1;
    step();
    id_nop();
    step();
    step();
    id_nop(); id_rd_URA = 7'd8; id_T_new = 2'd3;
    step();
    // md_cnt is 7 here and EX holds {8, 3}
    id_nop(); id_rs_URA = 7'd8; id_md_use = 1'b1;
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b1 || md_busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: flush=%b busy=%b, want 1 1", id_ex_flush, md_busy);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({pc_enable, if_id_enable, id_ex_flush, md_busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL mid_reset: pc=%b ifid=%b flush=%b busy=%b, want 1 1 0 0",
               pc_enable, if_id_enable, id_ex_flush, md_busy);
    end
    step();
    reset = 1'b0;
    #1;
    n_tests++;
    if (id_ex_flush !== 1'b0 || md_busy !== 1'b0 || pc_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: flush=%b busy=%b pc=%b, want 0 0 1",
               id_ex_flush, md_busy, pc_enable);
    end
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    id_nop();
    test_reset();
    test_lw_use();
    test_rt_and_tuse();
    test_youngest_match();
    test_zero_ura();
    test_mult_mfhi();
    test_back_to_back_div();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
